// File: rtl/ir_dir_cmd.sv
// IR command front-end: frame edge detect, NEC complement check, key map,
// same-key repeat suppression, and a small FWFT command FIFO.
module ir_dir_cmd #(
  parameter int unsigned HOLDOFF = 5_000_000,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_ready,
  input  logic [31:0] ir_data,
  input  logic        cmd_pop,
  output logic [2:0]  cmd_dout,
  output logic        cmd_empty,
  output logic        cmd_full,
  output logic [1:0]  dir,
  output logic        dir_valid,
  output logic        overflow,
  output logic [7:0]  err_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned HW = 23;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [2:0] CODE_NONE = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PUSH} state_t;

  state_t        state;
  logic          rdy_d;
  logic [15:0]   key_r;
  logic [2:0]    code_r;
  logic [2:0]    last_code;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    key_code;
  logic          new_frame;

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic          push, pop_ok, push_ok;
  logic [2:0]    head_nxt;

  // Only the key/complement bytes of the frame carry information here.
  logic unused_ok;
  assign unused_ok = ^ir_data[15:0];

  function automatic logic [2:0] map_key(input logic [7:0] key);
    case (key)
      8'h02:   map_key = 3'd0;
      8'h08:   map_key = 3'd1;
      8'h04:   map_key = 3'd2;
      8'h06:   map_key = 3'd3;
      8'h05:   map_key = 3'd4;
      default: map_key = CODE_NONE;
    endcase
  endfunction

  assign key_code  = map_key(key_r[7:0]);
  assign new_frame = ir_ready & ~rdy_d;

  // Frame FSM with repeat holdoff and direction latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rdy_d     <= 1'b0;
      key_r     <= '0;
      code_r    <= '0;
      last_code <= CODE_NONE;
      hold_cnt  <= '0;
      dir       <= '0;
      dir_valid <= 1'b0;
      err_cnt   <= '0;
    end else begin
      rdy_d <= ir_ready;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
      case (state)
        S_IDLE: begin
          if (new_frame) begin
            key_r <= ir_data[31:16];
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          if (key_r[15:8] != ~key_r[7:0]) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else if (key_code != CODE_NONE &&
                       !(key_code == last_code && hold_cnt != '0)) begin
            code_r <= key_code;
            state  <= S_PUSH;
          end
        end
        S_PUSH: begin
          state     <= S_IDLE;
          last_code <= code_r;
          hold_cnt  <= HOLD_LOAD;
          if (!code_r[2]) begin
            dir       <= code_r[1:0];
            dir_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO next-state; a simultaneous pop frees the slot for a push when full.
  always_comb begin
    push     = (state == S_PUSH);
    pop_ok   = cmd_pop & ~cmd_empty;
    push_ok  = push & (~cmd_full | pop_ok);
    wr_nxt   = wr_ptr + PW'(push_ok);
    rd_nxt   = rd_ptr + PW'(pop_ok);
    head_nxt = (push_ok && rd_nxt == wr_ptr) ? code_r : mem[rd_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= code_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_dout  <= '0;
      cmd_empty <= 1'b1;
      cmd_full  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      cmd_empty <= (rd_nxt == wr_nxt);
      cmd_full  <= (rd_nxt[AW-1:0] == wr_nxt[AW-1:0]) && (rd_nxt[AW] != wr_nxt[AW]);
      cmd_dout  <= (rd_nxt == wr_nxt) ? 3'd0 : head_nxt;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_dir_cmd.sv
// Directed bench for ir_dir_cmd (HOLDOFF=16, DEPTH=4) with hand-computed expectations.
module tb_ir_dir_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_ready;
  logic [31:0] ir_data;
  logic        cmd_pop;
  logic [2:0]  cmd_dout;
  logic        cmd_empty;
  logic        cmd_full;
  logic [1:0]  dir;
  logic        dir_valid;
  logic        overflow;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ir_dir_cmd #(.HOLDOFF(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ir_ready(ir_ready), .ir_data(ir_data), .cmd_pop(cmd_pop),
    .cmd_dout(cmd_dout), .cmd_empty(cmd_empty), .cmd_full(cmd_full), .dir(dir),
    .dir_valid(dir_valid), .overflow(overflow), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle ready pulse, then wait until the push (if any) has landed.
  task automatic frame(input logic [7:0] key, input logic [7:0] comp);
    ir_data  = {comp, key, 16'hA5A5};
    ir_ready = 1'b1;
    tick(1);
    ir_ready = 1'b0;
    tick(3);
  endtask

  task automatic send_key(input logic [7:0] key);
    frame(key, ~key);
  endtask

  task automatic pop_chk(input string tag, input logic [2:0] exp);
    chk(tag, 32'(cmd_dout), 32'(exp));
    cmd_pop = 1'b1;
    tick(1);
    cmd_pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ir_ready = 1'b0; ir_data = '0; cmd_pop = 1'b0;
    tick(2);
    chk("rst_dout", 32'(cmd_dout), 0);
    chk("rst_empty", 32'(cmd_empty), 1);
    chk("rst_full", 32'(cmd_full), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_dvalid", 32'(dir_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_err", 32'(err_cnt), 0);
    rst = 1'b0;
    tick(2);

    // Valid key held high for 100 cycles: one entry, latency E+2.
    ir_data = 32'hFD02_1234; ir_ready = 1'b1;
    tick(2);
    chk("lat_empty_e1", 32'(cmd_empty), 1);
    chk("lat_dvalid_e1", 32'(dir_valid), 0);
    tick(1);
    chk("lat_empty_e2", 32'(cmd_empty), 0);
    chk("lat_dout_e2", 32'(cmd_dout), 0);
    chk("lat_dir_e2", 32'(dir), 0);
    chk("lat_dvalid_e2", 32'(dir_valid), 1);
    tick(97);
    ir_ready = 1'b0;
    tick(3);
    pop_chk("hold_pop", 3'd0);
    chk("hold_one_entry", 32'(cmd_empty), 1);

    // Bad complement frames and saturation.
    frame(8'h02, 8'h00);
    chk("bad_err1", 32'(err_cnt), 1);
    chk("bad_nopush", 32'(cmd_empty), 1);
    for (int i = 1; i < 255; i++) frame(8'h02, 8'h00);
    chk("bad_err255", 32'(err_cnt), 255);
    for (int i = 255; i < 300; i++) frame(8'h02, 8'h00);
    chk("bad_err_sat", 32'(err_cnt), 255);
    chk("bad_nopush2", 32'(cmd_empty), 1);

    // Repeat filter: 06 at t0, 06 at t0+8 (filtered), 06 at t0+20, 04 at t0+23.
    tick(20);
    ir_data = 32'hF906_0000; ir_ready = 1'b1; tick(1); ir_ready = 1'b0; tick(7);
    ir_ready = 1'b1; tick(1); ir_ready = 1'b0; tick(11);
    ir_ready = 1'b1; tick(1); ir_ready = 1'b0; tick(2);
    ir_data = 32'hFB04_0000; ir_ready = 1'b1; tick(1); ir_ready = 1'b0; tick(3);
    chk("rep_dir", 32'(dir), 2);
    pop_chk("rep_pop0", 3'd3);
    pop_chk("rep_pop1", 3'd3);
    pop_chk("rep_pop2", 3'd2);
    chk("rep_empty", 32'(cmd_empty), 1);

    // FIFO boundary: five pushes into depth 4.
    tick(20);
    send_key(8'h02); send_key(8'h08); send_key(8'h04); send_key(8'h06); send_key(8'h05);
    chk("bnd_full", 32'(cmd_full), 1);
    chk("bnd_ovf", 32'(overflow), 1);
    chk("bnd_dir", 32'(dir), 3);
    pop_chk("bnd_pop0", 3'd0);
    pop_chk("bnd_pop1", 3'd1);
    pop_chk("bnd_pop2", 3'd2);
    pop_chk("bnd_pop3", 3'd3);
    chk("bnd_empty", 32'(cmd_empty), 1);
    chk("bnd_notfull", 32'(cmd_full), 0);
    chk("bnd_ovf_sticky", 32'(overflow), 1);

    // Reset mid-frame with two entries queued.
    send_key(8'h02); send_key(8'h08);
    ir_data = 32'hF906_0000; ir_ready = 1'b1;
    tick(1);
    rst = 1'b1;
    #1;
    chk("mid_rst_async_empty", 32'(cmd_empty), 1);
    ir_ready = 1'b0;
    tick(1);
    rst = 1'b0;
    chk("mid_empty", 32'(cmd_empty), 1);
    chk("mid_dvalid", 32'(dir_valid), 0);
    chk("mid_err", 32'(err_cnt), 0);
    chk("mid_ovf", 32'(overflow), 0);
    tick(4);
    chk("mid_discard", 32'(cmd_empty), 1);

    // Push coinciding with pop while full.
    send_key(8'h02); send_key(8'h08); send_key(8'h04); send_key(8'h06);
    chk("pp_full_before", 32'(cmd_full), 1);
    ir_data = 32'hFA05_0000; ir_ready = 1'b1;
    tick(1);
    ir_ready = 1'b0;
    tick(1);
    chk("pp_head", 32'(cmd_dout), 0);
    cmd_pop = 1'b1;
    tick(1);
    cmd_pop = 1'b0;
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_full_after", 32'(cmd_full), 1);
    chk("pp_dir_start", 32'(dir), 3);
    pop_chk("pp_pop1", 3'd1);
    pop_chk("pp_pop2", 3'd2);
    pop_chk("pp_pop3", 3'd3);
    pop_chk("pp_pop4", 3'd4);
    chk("pp_empty", 32'(cmd_empty), 1);

    // Unknown key with valid complement; pop on empty ignored.
    send_key(8'h11);
    chk("unk_empty", 32'(cmd_empty), 1);
    chk("unk_err", 32'(err_cnt), 0);
    cmd_pop = 1'b1; tick(1); cmd_pop = 1'b0;
    chk("pop_empty_dout", 32'(cmd_dout), 0);
    chk("pop_empty_empty", 32'(cmd_empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
